// File: rtl/line_burst_adapter_pkg.sv
// line_burst_pkg: shared types and widths for the L2 line-to-burst adapter.
package line_burst_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} adapter_state_t;
  localparam int BEATS   = 4;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
endpackage

// File: rtl/line_burst_adapter_if.sv
// line_burst_adapter_if: L2-side line port and memory-side burst port.
interface line_burst_adapter_if;
  import line_burst_pkg::*;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;
  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );
  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/line_burst_adapter.sv
// line_burst_adapter: serves one 256-bit line request as a four-beat 64-bit memory burst.
module line_burst_adapter
  import line_burst_pkg::*;
#(
  parameter int s_offset    = 5,
  parameter int burst_width = BURST_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  line_burst_adapter_if.slave  bus
);
  adapter_state_t    r_state, w_state;
  logic [1:0]        r_cnt, w_cnt;
  logic [LINE_W-1:0] r_buf, w_buf;
  logic [31:0]       r_addr, w_addr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_buf   <= w_buf;
      r_addr  <= w_addr;
    end
  end
  // Strobes come from state alone so resp_i never reaches read_o/write_o combinationally.
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_buf         = r_buf;
    w_addr        = r_addr;
    bus.read_o    = r_state == RD;
    bus.write_o   = r_state == WR;
    bus.resp_o    = r_state == DONE;
    bus.address_o = r_addr;
    bus.line_o    = r_buf;
    bus.burst_o   = r_buf[r_cnt*burst_width +: burst_width];
    case (r_state)
      IDLE: if (bus.read_i || bus.write_i) begin
        w_addr  = {bus.address_i[31:s_offset], {s_offset{1'b0}}};
        w_buf   = bus.read_i ? r_buf : bus.line_i;
        w_cnt   = '0;
        w_state = bus.read_i ? RD : WR;
      end
      RD, WR: if (bus.resp_i) begin
        if (r_state == RD) w_buf[r_cnt*burst_width +: burst_width] = bus.burst_i;
        w_cnt   = r_cnt + 2'd1;
        w_state = r_cnt == 2'(BEATS - 1) ? DONE : r_state;
      end
      default: w_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_line_burst_adapter.sv
// tb_line_burst_adapter: directed vector table plus reset/stall corner sequences.
module tb_line_burst_adapter;
  typedef struct packed {
    logic         rd;
    logic         wr;
    logic         echo;
    logic [31:0]  a;
    logic [255:0] ln;
    logic [255:0] bt;
    logic [7:0]   gap;
    logic [31:0]  ea;
    logic [255:0] el;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int resp_cnt = 0;
  logic [255:0] cap = '0;
  vec_t v [5];

  line_burst_adapter_if bus();
  line_burst_adapter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) resp_cnt <= resp_cnt + int'(bus.resp_o);

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
    else pass_cnt++;
  endtask

  task automatic xact(input vec_t t, input string nm);
    logic [255:0] bts;
    logic exp_rd, exp_wr;
    int r0;
    bts = t.echo ? cap : t.bt;
    exp_rd = t.rd;
    exp_wr = t.wr & ~t.rd;
    r0 = resp_cnt;
    bus.read_i = t.rd;
    bus.write_i = t.wr;
    bus.address_i = t.a;
    bus.line_i = t.ln;
    @(negedge clk);
    chk({nm, ".addr"}, 256'(bus.address_o), 256'(t.ea));
    for (int b = 0; b < 4; b++) begin
      if (b == 2) for (int g = 0; g < int'(t.gap); g++) begin
        bus.resp_i = 1'b0;
        chk({nm, ".gap_strobe"}, 256'({bus.read_o, bus.write_o}), 256'({exp_rd, exp_wr}));
        if (exp_wr) chk({nm, ".gap_burst"}, 256'(bus.burst_o), 256'(t.ln[128 +: 64]));
        @(negedge clk);
      end
      chk({nm, ".strobe"}, 256'({bus.read_o, bus.write_o}), 256'({exp_rd, exp_wr}));
      if (exp_wr) begin
        chk({nm, ".burst"}, 256'(bus.burst_o), 256'(t.ln[64*b +: 64]));
        cap[64*b +: 64] = bus.burst_o;
      end
      bus.resp_i = 1'b1;
      bus.burst_i = bts[64*b +: 64];
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    chk({nm, ".done"}, 256'({bus.resp_o, bus.read_o, bus.write_o}), 256'(3'b100));
    chk({nm, ".line"}, bus.line_o, t.el);
    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    @(negedge clk);
    chk({nm, ".resp_low"}, 256'(bus.resp_o), 256'(0));
    chk({nm, ".line_hold"}, bus.line_o, t.el);
    chk({nm, ".resp_count"}, 256'(resp_cnt - r0), 256'(1));
  endtask

  initial begin
    int r0;
    v[0] = '{rd: 1'b1, wr: 1'b0, echo: 1'b0, a: 32'h0000_1234, ln: '0,
             bt: {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, gap: 8'd0,
             ea: 32'h0000_1220, el: {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}};
    v[1] = '{rd: 1'b0, wr: 1'b1, echo: 1'b0, a: 32'h8000_003F,
             ln: 256'hDEADBEEF_CAFEF00D_01234567_89ABCDEF_0F1E2D3C_4B5A6978_FEDCBA98_76540123,
             bt: '0, gap: 8'd3, ea: 32'h8000_0020,
             el: 256'hDEADBEEF_CAFEF00D_01234567_89ABCDEF_0F1E2D3C_4B5A6978_FEDCBA98_76540123};
    v[2] = '{rd: 1'b1, wr: 1'b1, echo: 1'b0, a: 32'h0000_0040, ln: {256{1'b1}},
             bt: {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, gap: 8'd1,
             ea: 32'h0000_0040, el: {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}};
    v[3] = '{rd: 1'b0, wr: 1'b1, echo: 1'b0, a: 32'h0000_0105,
             ln: 256'h0001_0203_0405_0607_1011_1213_1415_1617_2021_2223_2425_2627_3031_3233_3435_3637,
             bt: '0, gap: 8'd0, ea: 32'h0000_0100,
             el: 256'h0001_0203_0405_0607_1011_1213_1415_1617_2021_2223_2425_2627_3031_3233_3435_3637};
    v[4] = '{rd: 1'b1, wr: 1'b0, echo: 1'b1, a: 32'h0000_0100, ln: '0, bt: '0, gap: 8'd2,
             ea: 32'h0000_0100,
             el: 256'h0001_0203_0405_0607_1011_1213_1415_1617_2021_2223_2425_2627_3031_3233_3435_3637};
    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    bus.address_i = '0;
    bus.line_i = '0;
    bus.burst_i = '0;
    bus.resp_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.strobes", 256'({bus.resp_o, bus.read_o, bus.write_o}), 256'(0));
    chk("reset.addr", 256'(bus.address_o), 256'(0));
    chk("reset.burst", 256'(bus.burst_o), 256'(0));
    chk("reset.line", bus.line_o, 256'(0));
    reset_n = 1'b1;
    @(negedge clk);
    bus.read_i = 1'b1;
    bus.address_i = 32'h0000_2000;
    @(negedge clk);
    chk("abort.read_o", 256'(bus.read_o), 256'(1));
    for (int b = 0; b < 2; b++) begin
      bus.resp_i = 1'b1;
      bus.burst_i = {16{4'h9}};
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    r0 = resp_cnt;
    reset_n = 1'b0;
    #1;
    chk("abort.strobes", 256'({bus.resp_o, bus.read_o, bus.write_o}), 256'(0));
    chk("abort.addr", 256'(bus.address_o), 256'(0));
    chk("abort.line", bus.line_o, 256'(0));
    bus.read_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort.no_resp", 256'(resp_cnt - r0), 256'(0));
    for (int i = 0; i < 5; i++) xact(v[i], $sformatf("vec%0d", i));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/line_burst_adapter.md
# line_burst_adapter

Memory-side responder for the L2 cache's physical-memory port. It accepts single 256-bit line read/write requests from the L2 and services each as a four-beat, 64-bit burst on the physical memory bus. It then returns one `resp_o` pulse with the assembled line. It sits between the L2 cache and the burst memory model or DRAM controller.

## Interface
- `s_offset`, default 5: log2 of line size in bytes; line is 256 bits.
- `burst_width`, default 64: beat width in bits; beats per line is 256/64 = 4.
- `clk` in, 1 bit: single clock, rising edge.
- `reset_n` in, 1 bit: reset, asynchronous assert, active-low.
- `line_i` in, 256 bits: write line from the L2.
- `line_o` out, 256 bits: read line to the L2.
- `address_i` in, 32 bits: line address from the L2.
- `read_i` in, 1 bit: line read request, held until `resp_o`.
- `write_i` in, 1 bit: line write request, held until `resp_o`.
- `resp_o` out, 1 bit: one-cycle completion pulse.
- `burst_i` in, 64 bits: read beat from memory.
- `burst_o` out, 64 bits: write beat to memory.
- `address_o` out, 32 bits: burst address, line-aligned.
- `read_o` out, 1 bit: burst read request.
- `write_o` out, 1 bit: burst write request.
- `resp_i` in, 1 bit: beat accepted (write) or beat valid (read).

## Operation
- **States:** IDLE, RD, WR, DONE. There is a 2-bit beat counter, a 256-bit line buffer and a 32-bit address register.
- **IDLE, request arrives:** `read_i` or `write_i` is sampled.
  - Latch the address as `{address_i[31:s_offset], 0}`.
  - On a write, latch `line_i` into the buffer.
  - Clear the counter.
  - Go to RD or WR.
- **Simultaneous requests:** if `read_i` and `write_i` are high together, read wins and `write_i` is ignored for that transaction.
- **RD:**
  - `read_o` = 1 and `address_o` = latched address.
  - On each cycle with `resp_i` = 1, write `burst_i` into `buffer[64*cnt +: 64]` and increment `cnt`.
  - On the beat where `cnt` = 3, go to DONE.
- **WR:**
  - `write_o` = 1 and `burst_o` = `buffer[64*cnt +: 64]`.
  - On each cycle with `resp_i` = 1, increment `cnt`.
  - On the beat where `cnt` = 3, go to DONE.
- **Gaps in `resp_i`:** these are legal. State and counter hold, and `read_o`/`write_o` stay high.
- **DONE:** `resp_o` = 1 for exactly one cycle, then return to IDLE. `read_o`/`write_o` are 0 in this cycle.
- **`line_o`:** driven from the buffer. It is valid in DONE and holds its value until the next transaction overwrites the buffer.
- **`resp_i` outside RD/WR:** ignored.
- **Request line changes mid-transaction:** `address_i`, `line_i`, `read_i` and `write_i` are not re-sampled until IDLE.

## Timing
- **Reset values** (asynchronous, while `reset_n` = 0):
  - State = IDLE.
  - `resp_o`, `read_o`, `write_o` = 0.
  - `address_o`, `burst_o`, `line_o` = 0.
  - Counter = 0 and buffer = 0.
- **Reset mid-burst:** aborts the transaction. No `resp_o` is issued, and the line is retried by the L2 after reset.
- **Request latency:** a request seen at edge 0 produces `read_o`/`write_o` high from cycle 1.
- **Completion latency:** if the four `resp_i` beats arrive in cycles k..k+3, `resp_o` is high in cycle k+4. The minimum total is 6 cycles from request to `resp_o`.
- **Back-to-back:** the earliest new request is sampled in the IDLE cycle after DONE. The L2 must drop its request on the edge where it sees `resp_o`, so the same request is never re-accepted.
- **Counter wrap:** the counter wraps 3→0 only on the final beat.
- **Registered outputs:** `address_o`, `read_o` and `write_o` are registered or derived from state only. There is no combinational path from `resp_i` to `read_o`/`write_o`.
- **`burst_o`:** may be combinational from `cnt` and the buffer.

## Structure
- **Package `line_burst_pkg`:**
  - state enum `adapter_state_t` (IDLE, RD, WR, DONE);
  - `BEATS` = 4;
  - `LINE_W` = 256;
  - `BURST_W` = 64.
- **Sub-modules:** none. Keep a single module containing one `always_ff` block (async reset) and one `always_comb` block for next-state and outputs.

## Test plan
- **Reset mid-read:** issue a read, deassert `reset_n` after 2 beats → outputs are immediately 0, there is no `resp_o`, and a following read completes normally.
- **Read, consecutive beats:** read at `address_i` = 0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles. Required:
  - `address_o` = 0x0000_1220;
  - `line_o` = {0x44..44, 0x33..33, 0x22..22, 0x11..11};
  - `resp_o` high for exactly 1 cycle, 4 cycles after the first beat.
- **Write, stalled beats:** write `line_i` = 0xDEAD..._0123 with a 3-cycle `resp_i` gap between beats 1 and 2. Required:
  - `burst_o` steps through `line_i[63:0]`, `[127:64]`, `[191:128]`, `[255:192]`;
  - `write_o` stays high through the gap;
  - one `resp_o`.
- **Simultaneous read and write:** assert both in IDLE → only `read_o` rises, and `write_o` stays 0 for the whole transaction.
- **Back-to-back transactions:** write then read to the same address, with the memory model echoing the stored line → the read returns the written line, and there is exactly one `resp_o` per transaction.
